fp_add_stage2_align: RTL and testbench
======================================

Name: fp_add_stage2_align

Overview:
Stage 2 of the 4-stage single-precision adder. It sits directly downstream of the special-case stage and consumes its pass-through fields and bypass word. It orders the operands into big and small, then right-shifts the small mantissa by exp_diff into a 27-bit datapath (24 mantissa bits plus guard, round and sticky). Valid, stall and flush are carried through so that stage 3 (add/sub) receives aligned operands or a bypass result.

Parameters:
SPLIT_SHIFT, 0, 0 = single register stage (latency 1); 1 = shifter split across two register stages (latency 2).
ALIGN_W, 27, aligned mantissa width (24 + G/R/S); fixed, not for override.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
valid_in  in  1  input beat valid
stall  in  1  hold all stage registers
flush  in  1  kill all in-flight beats
bypass_in  in  1  special-case shortcut flag from upstream
bypass_result_in  in  32  final IEEE-754 word when bypass_in
sign_A  in  1  sign of A
sign_B  in  1  effective sign of B (op already folded in)
exp_A  in  8  biased exponent of A
exp_B  in  8  biased exponent of B
man_A  in  24  mantissa of A with implicit bit
man_B  in  24  mantissa of B with implicit bit
exp_diff  in  8  |exp_A - exp_B|, unsigned
A_is_bigger  in  1  1 selects A as the big operand
valid_out  out  1  output beat valid
bypass_out  out  1  registered bypass_in
bypass_result_out  out  32  registered bypass_result_in
sign_big  out  1  sign of the big operand
sign_small  out  1  sign of the small operand
eff_sub  out  1  sign_big ^ sign_small
exp_big  out  8  exponent of the big operand (result exponent before normalise)
man_big  out  27  {big mantissa, 3'b000}
man_small  out  27  aligned small mantissa; bit 0 is sticky

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-pipeline): every output and every internal register goes to 0. The first beat after reset deasserts is sampled on the next clk edge.
- Operand ordering:
  - A_is_bigger=1 → big=A, small=B.
  - A_is_bigger=0 → big=B, small=A.
  - No re-compare inside this stage; ties follow A_is_bigger.
- Alignment: ext = {man_small, 3'b000}. The result is ext >> exp_diff. Bit 0 of the result = (shifted bit 0) OR (OR of all bits shifted out).
  - exp_diff >= 27 → man_small = {26'b0, |man_small_in}.
  - exp_diff = 0 → ext passes unchanged.
  - All 8 bits of exp_diff are honoured; no wrap on large values.
- Bypass beats: bypass_out=1 and bypass_result_out is passed through. sign/exp/man/eff_sub outputs are forced to 0.
- Register enable:
  - stall=0 → data registers load every cycle regardless of valid_in.
  - valid_out follows valid_in through the latency.
  - stall=1 → every stage register holds, including valid; inputs are ignored.
- flush=1 → all valid bits clear on that edge, data registers behave per stall, flush wins over stall. A beat presented on valid_in in the flush cycle is dropped.
- SPLIT_SHIFT=0: latency 1 cycle, single register bank on the outputs.
- SPLIT_SHIFT=1: latency 2 cycles.
  - Stage a registers ordering and a coarse shift by exp_diff[4:3]*8, accumulating sticky.
  - Stage a also registers a saturate flag (exp_diff>=32, or exp_diff[7:5]!=0) and exp_diff[2:0].
  - Stage b does the fine shift by 0..7, ORs sticky in, and applies the saturate rule (also saturate when 24..31 is exceeded past 27 bits).
  - Stage b output equals SPLIT_SHIFT=0 bit-for-bit.
  - stall and flush apply to both banks simultaneously; no bubble squeezing.
- No handshake back-pressure outputs. The pipeline controller fans stall out to all stages.

Decomposition:
- Package fp_add_pkg holds:
  - EXP_W=8, MAN_W=24, GRS_W=3, ALIGN_W=27.
  - QNAN=32'h7FC00000.
  - A struct for the stage-2→3 bundle (valid, bypass, bypass_result, signs, eff_sub, exp_big, man_big, man_small).
- One sub-module, fp_align_shift27: combinational right shifter with sticky and saturate. It has a coarse/fine split interface so SPLIT_SHIFT=1 can register between the halves.

Test Plan:
1. A=B=1.0 (exp 127, man 0x800000), exp_diff=0, A_is_bigger=1, valid_in=1 → after latency: man_big=0x4000000, man_small=0x4000000, exp_big=127, eff_sub=0, valid_out=1.
2. man_small=0x800001, exp_diff=4 → man_small=0x0400001 (sticky set). Same with exp_diff=1 and man 0x800000 → 0x2000000, sticky 0.
3. exp_diff=30 and exp_diff=200, man_small=0xFFFFFF → man_small=27'h1. Repeat with man_small=0 → 27'h0.
4. A_is_bigger=0, sign_A=0, sign_B=1 → sign_big=1, sign_small=0, eff_sub=1, exp_big=exp_B. Then bypass_in=1, bypass_result_in=0x7FC00000 → bypass_out=1, result passed, man/exp outputs 0.
5. Stream 4 beats; hold stall high for 3 cycles mid-stream → outputs frozen, no beat lost or duplicated, order preserved. Assert flush together with stall → valid_out=0 next edge, subsequent beats flow normally.
6. Assert rst asynchronously (between edges) while beats are in flight with SPLIT_SHIFT=1 → all outputs 0 immediately, valid_out stays 0 until the first post-reset beat emerges 2 cycles after sampling.

Source files
------------

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared widths, constants and the stage-2 to stage-3 bundle of the single-precision adder.
package fp_add_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int GRS_W = 3;
    localparam int ALIGN_W = MAN_W + GRS_W;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef struct packed {
        logic valid;
        logic bypass;
        logic [31:0] bypass_result;
        logic sign_big;
        logic sign_small;
        logic eff_sub;
        logic [EXP_W-1:0] exp_big;
        logic [ALIGN_W-1:0] man_big;
        logic [ALIGN_W-1:0] man_small;
    } s23_t;
    // Split-shifter intermediate: coarse-shifted bundle plus what the fine half still needs.
    typedef struct packed {
        s23_t op;
        logic sticky;
        logic sat;
        logic [2:0] fine;
    } s2a_t;
endpackage

// File: rtl/fp_add_stage2_align_shift.sv
// fp_align_shift27: right shifter for {mantissa, GRS} split into a coarse (0/8/16/24) and a fine (0..7) half.
module fp_align_shift27
    import fp_add_pkg::*;
(
    input  logic [MAN_W-1:0]   man_in,
    input  logic [1:0]         coarse_sel,
    output logic [ALIGN_W-1:0] coarse_man,
    output logic               coarse_sticky,
    input  logic [ALIGN_W-1:0] fine_man,
    input  logic               fine_sticky_in,
    input  logic [2:0]         fine_sel,
    input  logic               sat,
    output logic [ALIGN_W-1:0] man_out
);
    logic [ALIGN_W-1:0] ext, fine_sh;
    logic [4:0] c_amt;
    logic fine_st;
    // Totals of 27..31 need no special case: every bit lands in sticky, which equals |man.
    always_comb begin
        ext = {man_in, 3'b000};
        c_amt = {coarse_sel, 3'b000};
        coarse_man = ext >> c_amt;
        coarse_sticky = |(ext & ~(27'h7FFFFFF << c_amt));
        fine_sh = fine_man >> fine_sel;
        fine_st = fine_sticky_in | (|(fine_man & ~(27'h7FFFFFF << fine_sel)));
        man_out = sat ? {26'b0, (|fine_man) | fine_sticky_in} : {fine_sh[ALIGN_W-1:1], fine_sh[0] | fine_st};
    end
endmodule

// File: rtl/fp_add_stage2_align.sv
// fp_add_stage2_align: orders operands into big/small and aligns the small mantissa with sticky, latency 1 or 2.
module fp_add_stage2_align
    import fp_add_pkg::*;
#(
    parameter bit SPLIT_SHIFT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        bypass_in,
    input  logic [31:0] bypass_result_in,
    input  logic        sign_A,
    input  logic        sign_B,
    input  logic [7:0]  exp_A,
    input  logic [7:0]  exp_B,
    input  logic [23:0] man_A,
    input  logic [23:0] man_B,
    input  logic [7:0]  exp_diff,
    input  logic        A_is_bigger,
    output logic        valid_out,
    output logic        bypass_out,
    output logic [31:0] bypass_result_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic        eff_sub,
    output logic [7:0]  exp_big,
    output logic [26:0] man_big,
    output logic [26:0] man_small
);
    s23_t cur, nxt, out_d, out_q;
    logic [MAN_W-1:0] man_small_src;
    logic [ALIGN_W-1:0] c_man, f_man, sh_out;
    logic c_st, f_st, f_sat, sat_in;
    logic [2:0] f_sel;
    // Bypass beats zero every operand field so the shifter naturally yields 0.
    always_comb begin
        cur = '0;
        cur.valid = valid_in;
        cur.bypass = bypass_in;
        cur.bypass_result = bypass_result_in;
        cur.sign_big = ~bypass_in & (A_is_bigger ? sign_A : sign_B);
        cur.sign_small = ~bypass_in & (A_is_bigger ? sign_B : sign_A);
        cur.eff_sub = cur.sign_big ^ cur.sign_small;
        cur.exp_big = bypass_in ? '0 : (A_is_bigger ? exp_A : exp_B);
        cur.man_big = bypass_in ? '0 : {(A_is_bigger ? man_A : man_B), 3'b000};
        man_small_src = bypass_in ? '0 : (A_is_bigger ? man_B : man_A);
        sat_in = |exp_diff[7:5];
    end
    fp_align_shift27 u_shift (
        .man_in        (man_small_src),
        .coarse_sel    (exp_diff[4:3]),
        .coarse_man    (c_man),
        .coarse_sticky (c_st),
        .fine_man      (f_man),
        .fine_sticky_in(f_st),
        .fine_sel      (f_sel),
        .sat           (f_sat),
        .man_out       (sh_out)
    );
    if (SPLIT_SHIFT) begin : g_split
        s2a_t a_new, a_d, a_q;
        always_comb begin
            a_new = {cur, c_st, sat_in, exp_diff[2:0]};
            a_new.op.man_small = c_man;
            a_d = stall ? a_q : a_new;
            a_d.op.valid = ~flush & (stall ? a_q.op.valid : valid_in);
            nxt = a_q.op;
            nxt.man_small = sh_out;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) a_q <= '0;
            else a_q <= a_d;
        end
        assign f_man = a_q.op.man_small;
        assign f_st = a_q.sticky;
        assign f_sel = a_q.fine;
        assign f_sat = a_q.sat;
    end else begin : g_single
        always_comb begin
            nxt = cur;
            nxt.man_small = sh_out;
        end
        assign f_man = c_man;
        assign f_st = c_st;
        assign f_sel = exp_diff[2:0];
        assign f_sat = sat_in;
    end
    always_comb begin
        out_d = stall ? out_q : nxt;
        out_d.valid = ~flush & (stall ? out_q.valid : nxt.valid);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else out_q <= out_d;
    end
    assign valid_out = out_q.valid;
    assign bypass_out = out_q.bypass;
    assign bypass_result_out = out_q.bypass_result;
    assign sign_big = out_q.sign_big;
    assign sign_small = out_q.sign_small;
    assign eff_sub = out_q.eff_sub;
    assign exp_big = out_q.exp_big;
    assign man_big = out_q.man_big;
    assign man_small = out_q.man_small;
endmodule

// File: tb/tb_fp_add_stage2_align.sv
// tb_fp_add_stage2_align: directed checks of both shifter variants (index 0 = single stage, 1 = split).
module tb_fp_add_stage2_align;
    import fp_add_pkg::*;
    logic clk = 1'b0;
    logic rst, valid_in, stall, flush, bypass_in, sign_A, sign_B, A_is_bigger;
    logic [31:0] bypass_result_in;
    logic [7:0] exp_A, exp_B, exp_diff;
    logic [23:0] man_A, man_B;
    logic vo [2];
    logic bo [2];
    logic [31:0] br [2];
    logic sbg [2];
    logic ssm [2];
    logic es [2];
    logic [7:0] eb [2];
    logic [26:0] mb [2];
    logic [26:0] ms [2];
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        fp_add_stage2_align #(.SPLIT_SHIFT(g == 1)) u_dut (
            .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
            .bypass_in(bypass_in), .bypass_result_in(bypass_result_in),
            .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
            .man_A(man_A), .man_B(man_B), .exp_diff(exp_diff), .A_is_bigger(A_is_bigger),
            .valid_out(vo[g]), .bypass_out(bo[g]), .bypass_result_out(br[g]),
            .sign_big(sbg[g]), .sign_small(ssm[g]), .eff_sub(es[g]),
            .exp_big(eb[g]), .man_big(mb[g]), .man_small(ms[g])
        );
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic s23_t mk(input logic v, input logic b, input logic [31:0] r, input logic sb,
                                input logic ss, input logic [7:0] e, input logic [26:0] mbg, input logic [26:0] msm);
        s23_t x;
        x.valid = v; x.bypass = b; x.bypass_result = r; x.sign_big = sb; x.sign_small = ss;
        x.eff_sub = sb ^ ss; x.exp_big = e; x.man_big = mbg; x.man_small = msm;
        return x;
    endfunction
    task automatic chk(input string tag, input int i, input s23_t e);
        logic [98:0] o;
        o = {vo[i], bo[i], br[i], sbg[i], ssm[i], es[i], eb[i], mb[i], ms[i]};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d: got %h expected %h", tag, i, o, e);
        end
    endtask
    task automatic chk2(input string tag, input s23_t e);
        chk(tag, 0, e);
        chk(tag, 1, e);
    endtask
    task automatic chk_ve(input string tag, input int i, input logic [8:0] e);
        logic [8:0] o;
        o = {vo[i], eb[i]};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d: got valid/exp %h expected %h", tag, i, o, e);
        end
    endtask
    task automatic op(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb_i,
                      input logic [23:0] ma, input logic [23:0] mb_i, input logic [7:0] ed, input logic aib);
        sign_A = sa; sign_B = sb; exp_A = ea; exp_B = eb_i;
        man_A = ma; man_B = mb_i; exp_diff = ed; A_is_bigger = aib;
    endtask
    task automatic beat(input logic v, input logic [7:0] e, input logic st, input logic fl);
        valid_in = v; stall = st; flush = fl;
        op(1'b0, 1'b0, e, e, 24'h800000, 24'h800000, 8'd0, 1'b1);
    endtask
    task automatic data(input string tag, input logic [7:0] ea, input logic [23:0] msm_in,
                        input logic [7:0] ed, input logic [26:0] exp_ms);
        op(1'b0, 1'b0, ea, 8'd127, 24'h800000, msm_in, ed, 1'b1);
        tick;
        tick;
        chk2(tag, mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, ea, 27'h4000000, exp_ms));
    endtask
    logic [8:0] s_v [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] s_e [9] = '{8'd11, 8'd12, 8'd13, 8'd13, 8'd13, 8'd13, 8'd14, 8'd0, 8'd0};
    logic s_s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [8:0] x0 [9] = '{9'h10B, 9'h10C, 9'h10C, 9'h10C, 9'h10C, 9'h10D, 9'h10E, 9'h000, 9'h000};
    logic [8:0] x1 [9] = '{9'h000, 9'h10B, 9'h10B, 9'h10B, 9'h10B, 9'h10C, 9'h10D, 9'h10E, 9'h000};
    initial begin
        rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        bypass_in = 1'b0; bypass_result_in = 32'h0;
        op(1'b0, 1'b0, 8'd0, 8'd0, 24'h0, 24'h0, 8'd0, 1'b0);
        tick;
        chk2("reset", '0);
        tick;
        rst = 1'b0;
        valid_in = 1'b1;
        op(1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 8'd0, 1'b1);
        tick;
        tick;
        chk2("equal_ops", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h4000000));
        data("sticky_d4", 8'd131, 24'h800001, 8'd4, 27'h0400001);
        data("shift_d1", 8'd128, 24'h800000, 8'd1, 27'h2000000);
        data("fine_d13", 8'd140, 24'hFFF001, 8'd13, 27'h0003FFD);
        data("coarse_d24", 8'd151, 24'hC00000, 8'd24, 27'h0000006);
        data("edge_d26", 8'd153, 24'h800000, 8'd26, 27'h0000001);
        data("sat_d27", 8'd154, 24'h800000, 8'd27, 27'h0000001);
        data("sat_d30", 8'd157, 24'hFFFFFF, 8'd30, 27'h0000001);
        data("sat_d32", 8'd159, 24'h800000, 8'd32, 27'h0000001);
        data("sat_d200", 8'd254, 24'hFFFFFF, 8'd200, 27'h0000001);
        data("zero_d30", 8'd157, 24'h000000, 8'd30, 27'h0000000);
        op(1'b0, 1'b1, 8'd100, 8'd102, 24'h900000, 24'hC00000, 8'd2, 1'b0);
        tick;
        tick;
        chk2("b_bigger", mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'd102, 27'h6000000, 27'h1200000));
        bypass_in = 1'b1;
        bypass_result_in = QNAN;
        tick;
        tick;
        chk2("bypass", mk(1'b1, 1'b1, QNAN, 1'b0, 1'b0, 8'd0, 27'h0, 27'h0));
        bypass_in = 1'b0;
        bypass_result_in = 32'h0;
        beat(1'b0, 8'd0, 1'b0, 1'b0);
        tick;
        tick;
        for (int k = 0; k < 9; k++) begin
            beat(s_v[k][0], s_e[k], s_s[k], 1'b0);
            tick;
            chk_ve("stream_stall", 0, x0[k]);
            chk_ve("stream_stall", 1, x1[k]);
        end
        beat(1'b1, 8'd21, 1'b0, 1'b0);
        tick;
        beat(1'b1, 8'd22, 1'b1, 1'b1);
        tick;
        chk_ve("flush_stall", 0, 9'h015);
        chk_ve("flush_stall", 1, 9'h000);
        beat(1'b1, 8'd23, 1'b0, 1'b0);
        tick;
        chk_ve("post_flush1", 0, 9'h117);
        chk_ve("post_flush1", 1, 9'h015);
        beat(1'b0, 8'd0, 1'b0, 1'b0);
        tick;
        chk_ve("post_flush2", 0, 9'h000);
        chk_ve("post_flush2", 1, 9'h117);
        tick;
        chk_ve("post_flush3", 1, 9'h000);
        beat(1'b1, 8'd40, 1'b0, 1'b0);
        tick;
        beat(1'b1, 8'd41, 1'b0, 1'b0);
        tick;
        #3;
        rst = 1'b1;
        #1;
        chk2("async_rst", '0);
        tick;
        chk2("rst_held", '0);
        rst = 1'b0;
        beat(1'b1, 8'd30, 1'b0, 1'b0);
        tick;
        chk_ve("first_beat1", 0, 9'h11E);
        chk_ve("first_beat1", 1, 9'h000);
        beat(1'b0, 8'd0, 1'b0, 1'b0);
        tick;
        chk_ve("first_beat2", 0, 9'h000);
        chk_ve("first_beat2", 1, 9'h11E);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
